// File: rtl/blink_meter.sv
// Blink meter: measures the period of a slow asynchronous square wave in
// clk cycles, reports lock while rising edges keep arriving within
// TIMEOUT_CYCLES, and flags a timeout when they stop.
// Optional glitch filter: define BLINK_METER_FILTER_EN to enable it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no edge seen since reset; waiting for the first rising edge
// ARMED   | counting cycles since the last accepted rising edge
// TIMEOUT | no edge within TIMEOUT_CYCLES; waiting to restart counting
module blink_meter #(
   parameter int unsigned TIMEOUT_CYCLES = 100000000,
   parameter int unsigned FILTER_CYCLES  = 16
) (
   input  logic        CLOCK_50,
   input  logic        rst,
   input  logic        sig_in,
   output logic [31:0] period,
   output logic        period_valid,
   output logic        locked,
   output logic        timeout,
   output logic [7:0]  LEDG
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [31:0] cnt, cnt_nx, cnt_inc;
   logic [31:0] period_nx;
   logic        period_valid_nx, locked_nx, timeout_nx;
   logic        sync_1, sync_2;
   logic        level, level_d;
   logic        rise;

   // Two-flop synchroniser for the asynchronous input.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= sig_in;
         sync_2 <= sync_1;
      end
   end

`ifdef BLINK_METER_FILTER_EN
   localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_CYCLES - 1);

   logic [FW-1:0] flt_cnt;

   // Glitch filter: the level flips only after the synchronised input has
   // disagreed with it for FILTER_CYCLES consecutive cycles.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         level   <= 1'b0;
         flt_cnt <= '0;
      end else if (sync_2 == level) begin
         flt_cnt <= FLT_LOAD;
      end else if (flt_cnt == '0) begin
         level   <= sync_2;
         flt_cnt <= FLT_LOAD;
      end else begin
         flt_cnt <= flt_cnt - FW'(1);
      end
   end
`else
   logic unused_cfg;

   assign level      = sync_2;
   assign unused_cfg = ^FILTER_CYCLES;
`endif

   assign rise    = level & ~level_d;
   assign cnt_inc = cnt + 32'd1;

   // State and datapath registers.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         level_d      <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         period       <= period_nx;
         period_valid <= period_valid_nx;
         locked       <= locked_nx;
         timeout      <= timeout_nx;
         level_d      <= level;
      end
   end

   // Next-state and next-output decode; a rising edge beats timeout expiry.
   always_comb begin
      state_nx        = state;
      cnt_nx          = cnt;
      period_nx       = period;
      period_valid_nx = 1'b0;
      locked_nx       = locked;
      timeout_nx      = timeout;
      case (state)
         IDLE: begin
            if (rise) begin
               cnt_nx   = '0;
               state_nx = ARMED;
            end
         end
         ARMED: begin
            if (rise) begin
               period_nx       = cnt_inc;
               period_valid_nx = 1'b1;
               locked_nx       = 1'b1;
               cnt_nx          = '0;
            end else if (cnt_inc == TIMEOUT_CYCLES) begin
               cnt_nx     = cnt_inc;
               locked_nx  = 1'b0;
               timeout_nx = 1'b1;
               state_nx   = TIMEOUT;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         TIMEOUT: begin
            if (rise) begin
               cnt_nx     = '0;
               timeout_nx = 1'b0;
               state_nx   = ARMED;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign LEDG = {5'b0, timeout, locked, level};

endmodule
